// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF and LS requesters, the arbiter and the unified memory port.
// The slave modport is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_req_addr;
    logic        ls_req_wen;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_mask;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_mask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output mem_req_valid, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_mask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  mem_req_valid, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// One transaction in flight; LS has priority, bounded by an IF anti-starvation counter.
module mem_port_arbiter #(
    parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_port_arbiter_if.slave bus,
    output logic              o_busy
);
    localparam int unsigned CntW =
        (FETCH_STARVE_LIMIT > 0) ? $clog2(FETCH_STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(FETCH_STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q;
    logic            owner_ls_q;
    logic            is_read_q;
    logic [CntW-1:0] starve_q;

    logic            mem_req_valid_q;
    logic [31:0]     mem_addr_q;
    logic            mem_ren_q;
    logic            mem_wen_q;
    logic [31:0]     mem_wdata_q;
    logic [3:0]      mem_mask_q;

    logic if_force;
    logic ls_grant;
    logic if_grant;
    logic rsp_fire;

    always_comb begin
        if_force = (FETCH_STARVE_LIMIT != 0) && (starve_q == StarveMax) && bus.if_req_valid;
        // Gated by reset so that every output reads 0 while reset is held.
        ls_grant = !i_rst && (state_q == StIdle) && bus.ls_req_valid && !if_force;
        if_grant = !i_rst && (state_q == StIdle) && bus.if_req_valid &&
                   (!bus.ls_req_valid || if_force);
        rsp_fire = (state_q == StWait) && bus.mem_rsp_valid;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= StIdle;
            owner_ls_q      <= 1'b1;
            is_read_q       <= 1'b0;
            starve_q        <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_ren_q       <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_mask_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ls_grant) begin
                        state_q         <= StIssue;
                        owner_ls_q      <= 1'b1;
                        is_read_q       <= !bus.ls_req_wen;
                        mem_req_valid_q <= 1'b1;
                        mem_addr_q      <= bus.ls_req_addr & 32'hFFFF_FFFC;
                        mem_ren_q       <= !bus.ls_req_wen;
                        mem_wen_q       <= bus.ls_req_wen;
                        mem_wdata_q     <= bus.ls_req_wdata;
                        mem_mask_q      <= bus.ls_req_mask;
                        if (bus.if_req_valid && (starve_q != StarveMax)) begin
                            starve_q <= starve_q + CntW'(1);
                        end
                    end else if (if_grant) begin
                        state_q         <= StIssue;
                        owner_ls_q      <= 1'b0;
                        is_read_q       <= 1'b1;
                        mem_req_valid_q <= 1'b1;
                        mem_addr_q      <= bus.if_req_addr & 32'hFFFF_FFFC;
                        mem_ren_q       <= 1'b1;
                        mem_wen_q       <= 1'b0;
                        mem_wdata_q     <= '0;
                        mem_mask_q      <= 4'b1111;
                        starve_q        <= '0;
                    end
                end
                StIssue: begin
                    if (bus.mem_req_ready) begin
                        state_q         <= StWait;
                        mem_req_valid_q <= 1'b0;
                        mem_ren_q       <= 1'b0;
                        mem_wen_q       <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.mem_rsp_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.if_req_ready  = if_grant;
        bus.ls_req_ready  = ls_grant;
        bus.if_rsp_valid  = rsp_fire && !owner_ls_q;
        bus.if_rsp_rdata  = (rsp_fire && !owner_ls_q) ? bus.mem_rsp_rdata : 32'h0;
        bus.ls_rsp_valid  = rsp_fire && owner_ls_q;
        // Store acks carry no data.
        bus.ls_rsp_rdata  = (rsp_fire && owner_ls_q && is_read_q) ? bus.mem_rsp_rdata : 32'h0;
        bus.mem_req_valid = mem_req_valid_q;
        bus.mem_addr      = mem_addr_q;
        bus.mem_ren       = mem_ren_q;
        bus.mem_wen       = mem_wen_q;
        bus.mem_wdata     = mem_wdata_q;
        bus.mem_mask      = mem_mask_q;
        o_busy            = (state_q != StIdle);
    end
endmodule
